// File: rtl/dac_update_sched_if.sv
// Write-request channel used by each requester (host, scan) of the DAC update scheduler.
// The requester drives the master side; the scheduler answers with a single-cycle ack.
interface dac_update_sched_if;
  logic        req;
  logic [4:0]  addr;
  logic [15:0] dat;
  logic        upd;
  logic        ack;

  modport master (output req, output addr, output dat, output upd, input ack);
  modport slave  (input req, input addr, input dat, input upd, output ack);
endinterface

// File: rtl/dac_update_sched.sv
// Arbiter/sequencer sharing the threshold-DAC storage write port between host and scan,
// launching serial updates on request or after a quiet hold-off, and fencing writes while busy.
module dac_update_sched #(
  parameter int HOLDOFF     = 1024,
  parameter bit AUTO_UPDATE = 1'b1,
  parameter int BUSY_TO     = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  dac_update_sched_if.slave host,
  dac_update_sched_if.slave scan,
  output logic              dac_we_o,
  output logic [4:0]        dac_waddr_o,
  output logic [15:0]       dac_dat_o,
  output logic              dac_update_o,
  input  logic              dac_busy_i,
  output logic              dirty_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic [CNT_W-1:0]  update_count_o
);

  localparam int HO_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam int TO_W = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
  localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(BUSY_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_e;

  state_e           state_r;
  state_e           state_s;
  logic             grant_s;
  logic             grant_scan_s;
  logic             timeout_s;
  logic             done_s;
  logic             any_req_s;

  logic             rr_scan_r;    // 1: scan wins the next simultaneous request
  logic             win_scan_r;   // requester owning the current WRITE cycle
  logic             upd_lat_r;
  logic             pend_upd_r;
  logic             dirty_r;
  logic [HO_W-1:0]  ho_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             err_r;
  logic [CNT_W-1:0] upd_cnt_r;
  logic             we_r;
  logic [4:0]       waddr_r;
  logic [15:0]      wdat_r;
  logic             update_r;

  assign any_req_s = host.req | scan.req;

  // Next-state decode, arbitration and busy-handshake events.
  always_comb begin
    state_s      = state_r;
    grant_s      = 1'b0;
    grant_scan_s = 1'b0;
    timeout_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          if (!dac_busy_i) begin
            grant_s      = 1'b1;
            grant_scan_s = scan.req & (~host.req | rr_scan_r);
            state_s      = ST_WRITE;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (pend_upd_r || (AUTO_UPDATE && dirty_r && (ho_cnt_r == HO_MAX))) begin
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE:  state_s = ST_IDLE;
      ST_LAUNCH: state_s = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (dac_busy_i) begin
          state_s = ST_WAIT_LO;
        end else if (to_cnt_r == TO_MAX) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!dac_busy_i) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_LO;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Acks are a pure decode so the requester sees acceptance in the WRITE cycle itself.
  assign host.ack = (state_r == ST_WRITE) & ~win_scan_r;
  assign scan.ack = (state_r == ST_WRITE) &  win_scan_r;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write-port and launch-pulse output registers, winner latch and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_r       <= 1'b0;
      waddr_r    <= 5'd0;
      wdat_r     <= 16'd0;
      update_r   <= 1'b0;
      upd_lat_r  <= 1'b0;
      win_scan_r <= 1'b0;
      rr_scan_r  <= 1'b0;
    end else begin
      we_r     <= grant_s;
      update_r <= (state_s == ST_LAUNCH);
      if (grant_s) begin
        waddr_r    <= grant_scan_s ? scan.addr : host.addr;
        wdat_r     <= grant_scan_s ? scan.dat  : host.dat;
        upd_lat_r  <= grant_scan_s ? scan.upd  : host.upd;
        win_scan_r <= grant_scan_s;
        rr_scan_r  <= ~grant_scan_s;
      end
    end
  end

  // Dirty / pending-update bookkeeping: a write marks dirty, a launch consumes both.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dirty_r    <= 1'b0;
      pend_upd_r <= 1'b0;
    end else if (state_r == ST_WRITE) begin
      dirty_r    <= 1'b1;
      pend_upd_r <= pend_upd_r | upd_lat_r;
    end else if (state_r == ST_LAUNCH) begin
      dirty_r    <= 1'b0;
      pend_upd_r <= 1'b0;
    end
  end

  // Hold-off and busy-timeout counters, both saturating at their terminal values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ho_cnt_r <= '0;
      to_cnt_r <= '0;
    end else begin
      if ((state_r == ST_WRITE) || (state_r == ST_LAUNCH)) begin
        ho_cnt_r <= '0;
      end else if ((state_r == ST_IDLE) && dirty_r && !any_req_s && (ho_cnt_r != HO_MAX)) begin
        ho_cnt_r <= ho_cnt_r + HO_W'(1);
      end
      if (state_r == ST_LAUNCH) begin
        to_cnt_r <= '0;
      end else if ((state_r == ST_WAIT_HI) && !dac_busy_i && (to_cnt_r != TO_MAX)) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  // Sticky timeout flag (a same-cycle timeout beats the clear) and completed-update counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r     <= 1'b0;
      upd_cnt_r <= '0;
    end else begin
      if (timeout_s) begin
        err_r <= 1'b1;
      end else if (err_clr_i) begin
        err_r <= 1'b0;
      end
      if (done_s) begin
        upd_cnt_r <= upd_cnt_r + CNT_W'(1);
      end
    end
  end

  assign dac_we_o       = we_r;
  assign dac_waddr_o    = waddr_r;
  assign dac_dat_o      = wdat_r;
  assign dac_update_o   = update_r;
  assign dirty_o        = dirty_r;
  assign err_o          = err_r;
  assign update_count_o = upd_cnt_r;

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed bench for dac_update_sched: table of single writes plus hand sequences for
// arbitration, busy fencing, hold-off auto-update, busy timeout and mid-update reset.
module tb_dac_update_sched;
  localparam int HOLDOFF = 16;
  localparam int BUSY_TO = 8;
  localparam int CNT_W   = 16;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             err_clr = 1'b0;
  logic             busy;
  logic             dac_we;
  logic [4:0]       dac_waddr;
  logic [15:0]      dac_dat;
  logic             dac_update;
  logic             dirty;
  logic             err;
  logic [CNT_W-1:0] ucount;

  int checks = 0;
  int errors = 0;

  dac_update_sched_if host_if ();
  dac_update_sched_if scan_if ();

  dac_update_sched #(
    .HOLDOFF(HOLDOFF), .AUTO_UPDATE(1'b1), .BUSY_TO(BUSY_TO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .host(host_if), .scan(scan_if),
    .dac_we_o(dac_we), .dac_waddr_o(dac_waddr), .dac_dat_o(dac_dat),
    .dac_update_o(dac_update), .dac_busy_i(busy), .dirty_o(dirty),
    .err_o(err), .err_clr_i(err_clr), .update_count_o(ucount)
  );

  always #5 clk = ~clk;

  // Controller busy model: busy is seen by the DUT from the 2nd cycle after the pulse, for bm_len cycles.
  bit bm_en  = 1'b1;
  int bm_len = 4;
  int bm_t   = -1;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) bm_t <= -1;
    else if (bm_en && dac_update) bm_t <= 0;
    else if (bm_t >= 0 && bm_t < 2 + bm_len) bm_t <= bm_t + 1;
    else bm_t <= -1;
  end
  assign busy = (bm_t >= 2) && (bm_t < 2 + bm_len);

  typedef struct {
    bit          use_scan;
    logic [4:0]  addr;
    logic [15:0] dat;
    logic [4:0]  junk_a;
    logic [15:0] junk_d;
    bit          exp_hack;
    bit          exp_sack;
    logic [4:0]  exp_addr;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    host_if.req = 1'b0; host_if.upd = 1'b0;
    scan_if.req = 1'b0; scan_if.upd = 1'b0;
  endtask

  task automatic set_req(input bit s, input logic [4:0] a, input logic [15:0] d, input bit u);
    if (s) begin
      scan_if.addr = a; scan_if.dat = d; scan_if.upd = u; scan_if.req = 1'b1;
    end else begin
      host_if.addr = a; host_if.dat = d; host_if.upd = u; host_if.req = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop_reqs();
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dac_we) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    bit ok;
    int n;
    int pulses;
    int stray;

    vecs[0] = '{1'b0, 5'h09, 16'h0ABC, 5'h1F, 16'hFFFF, 1'b1, 1'b0, 5'h09, 16'h0ABC};
    vecs[1] = '{1'b1, 5'h1A, 16'h0123, 5'h05, 16'h5555, 1'b0, 1'b1, 5'h1A, 16'h0123};
    vecs[2] = '{1'b0, 5'h00, 16'hFFFF, 5'h1F, 16'h0000, 1'b1, 1'b0, 5'h00, 16'hFFFF};
    vecs[3] = '{1'b1, 5'h1F, 16'h8001, 5'h00, 16'h7FFE, 1'b0, 1'b1, 5'h1F, 16'h8001};

    drop_reqs();
    host_if.addr = 5'h00; host_if.dat = 16'h0000;
    scan_if.addr = 5'h00; scan_if.dat = 16'h0000;

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst_we", dac_we, 1'b0);
    chk("rst_update", dac_update, 1'b0);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_count", ucount, 16'd0);
    chk("rst_hack", host_if.ack, 1'b0);
    chk("rst_sack", scan_if.ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single writes; the idle requester shows junk that must be ignored.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].use_scan) begin
        host_if.addr = vecs[v].junk_a; host_if.dat = vecs[v].junk_d;
      end else begin
        scan_if.addr = vecs[v].junk_a; scan_if.dat = vecs[v].junk_d;
      end
      set_req(vecs[v].use_scan, vecs[v].addr, vecs[v].dat, 1'b0);
      wait_we(ok);
      chk("vec_we_seen", ok, 1'b1);
      chk("vec_waddr", dac_waddr, vecs[v].exp_addr);
      chk("vec_wdat", dac_dat, vecs[v].exp_dat);
      chk("vec_hack", host_if.ack, vecs[v].exp_hack);
      chk("vec_sack", scan_if.ack, vecs[v].exp_sack);
      chk("vec_no_update", dac_update, 1'b0);
      @(negedge clk);
      drop_reqs();
      chk("vec_dirty", dirty, 1'b1);
      chk("vec_we_one_cycle", dac_we, 1'b0);
    end

    // Both requesters continuously: host, scan, host, scan, one write every 2 cycles.
    do_reset();
    set_req(1'b0, 5'h01, 16'h1111, 1'b0);
    set_req(1'b1, 5'h02, 16'h2222, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("rr_we", dac_we, (i % 2) == 1);
      chk("rr_hack", host_if.ack, (i == 1) || (i == 5));
      chk("rr_sack", scan_if.ack, (i == 3) || (i == 7));
      if (i % 2 == 1) chk("rr_waddr", dac_waddr, ((i % 4) == 1) ? 5'h01 : 5'h02);
    end
    drop_reqs();

    // Scan write with upd, busy 64 cycles; host request is fenced until busy falls.
    do_reset();
    bm_en = 1'b1; bm_len = 64;
    set_req(1'b1, 5'h03, 16'h0333, 1'b1);
    wait_we(ok);
    chk("upd_we_seen", ok, 1'b1);
    chk("upd_sack", scan_if.ack, 1'b1);
    @(negedge clk);
    drop_reqs();
    @(negedge clk);
    chk("upd_launch", dac_update, 1'b1);
    chk("upd_dirty_before", dirty, 1'b1);
    @(negedge clk);
    chk("upd_pulse_width", dac_update, 1'b0);
    chk("upd_dirty_after", dirty, 1'b0);
    set_req(1'b0, 5'h04, 16'h0444, 1'b0);
    pulses = 1; stray = 0; n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dac_update) pulses++;
      if (dac_we && !host_if.ack) stray++;
      if (host_if.ack) begin
        n = i;
        break;
      end
    end
    // Busy is sampled high for 64 cycles from launch+2; ack lands 2 cycles after it falls.
    chk("upd_ack_delay", n, 67);
    chk("upd_pulses", pulses, 1);
    chk("upd_no_stray_we", stray, 0);
    chk("upd_count", ucount, 16'd1);
    chk("upd_host_waddr", dac_waddr, 5'h04);
    @(negedge clk);
    drop_reqs();

    // Auto-update: HOLDOFF quiet cycles after the WRITE cycle, then the launch cycle.
    do_reset();
    bm_en = 1'b1; bm_len = 4;
    set_req(1'b0, 5'h11, 16'h0044, 1'b0);
    wait_we(ok);
    chk("auto_we_seen", ok, 1'b1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) drop_reqs();
      if (dac_update) begin
        n = i;
        break;
      end
    end
    chk("auto_delay", n, HOLDOFF + 1);
    @(negedge clk);
    chk("auto_pulse_width", dac_update, 1'b0);
    chk("auto_dirty_clear", dirty, 1'b0);
    for (int i = 0; i < 20 && ucount != 16'd1; i++) @(negedge clk);
    chk("auto_count", ucount, 16'd1);

    // Busy never rises: sticky timeout after BUSY_TO wait cycles, FSM back in IDLE, clear.
    do_reset();
    bm_en = 1'b0;
    set_req(1'b0, 5'h12, 16'h0055, 1'b1);
    wait_we(ok);
    chk("to_we_seen", ok, 1'b1);
    @(negedge clk);
    drop_reqs();
    @(negedge clk);
    chk("to_launch", dac_update, 1'b1);
    for (int i = 1; i <= BUSY_TO; i++) @(negedge clk);
    chk("to_err_not_yet", err, 1'b0);
    @(negedge clk);
    chk("to_err_set", err, 1'b1);
    set_req(1'b0, 5'h13, 16'h0066, 1'b0);
    @(negedge clk);
    chk("to_idle_hack", host_if.ack, 1'b1);
    chk("to_idle_we", dac_we, 1'b1);
    chk("to_err_sticky", err, 1'b1);
    @(negedge clk);
    drop_reqs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_cleared", err, 1'b0);
    chk("to_count", ucount, 16'd0);

    // Reset while the second update is in WAIT_LO.
    do_reset();
    bm_en = 1'b1; bm_len = 4;
    set_req(1'b1, 5'h07, 16'h0777, 1'b1);
    wait_we(ok);
    @(negedge clk);
    drop_reqs();
    for (int i = 0; i < 40 && ucount != 16'd1; i++) @(negedge clk);
    chk("wlo_first_count", ucount, 16'd1);
    set_req(1'b1, 5'h08, 16'h0888, 1'b1);
    wait_we(ok);
    chk("wlo_we_seen", ok, 1'b1);
    @(negedge clk);
    drop_reqs();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dac_update) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wlo_launch_seen", ok, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wlo_rst_we", dac_we, 1'b0);
    chk("wlo_rst_waddr", dac_waddr, 5'h00);
    chk("wlo_rst_dat", dac_dat, 16'h0000);
    chk("wlo_rst_update", dac_update, 1'b0);
    chk("wlo_rst_dirty", dirty, 1'b0);
    chk("wlo_rst_err", err, 1'b0);
    chk("wlo_rst_count", ucount, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(1'b0, 5'h15, 16'h0F0F, 1'b0);
    wait_we(ok);
    chk("wlo_post_we_seen", ok, 1'b1);
    chk("wlo_post_hack", host_if.ack, 1'b1);
    chk("wlo_post_waddr", dac_waddr, 5'h15);
    chk("wlo_post_dat", dac_dat, 16'h0F0F);
    @(negedge clk);
    drop_reqs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
